// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: GPR write-back slot, architectural HI/LO with
// forwarding to EX, and a retired-instruction counter.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_mem,
  input  logic              stall_wb,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_whilo,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  output logic [ADDR_W-1:0] wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_whilo,
  output logic [DATA_W-1:0] wb_hi,
  output logic [DATA_W-1:0] wb_lo,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [DATA_W-1:0] hi_fwd,
  output logic [DATA_W-1:0] lo_fwd,
  output logic [CNT_W-1:0]  retired_cnt
);

  logic [ADDR_W-1:0] wd_q, wd_d;
  logic              wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              whilo_q, whilo_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] hi_arch_q, hi_arch_d;
  logic [DATA_W-1:0] lo_arch_q, lo_arch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              slot_clear;
  logic              retire;

  // A bubble is inserted on flush or when MEM stalls but WB drains.
  assign slot_clear = flush || (stall_mem && !stall_wb);
  assign retire     = !stall_wb;

  always_comb begin
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    whilo_d = whilo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    valid_d = valid_q;
    if (slot_clear) begin
      wd_d    = '0;
      wreg_d  = 1'b0;
      wdata_d = '0;
      whilo_d = 1'b0;
      hi_d    = '0;
      lo_d    = '0;
      valid_d = 1'b0;
    end else if (!stall_mem) begin
      wd_d    = mem_wd;
      wreg_d  = mem_wreg;
      wdata_d = mem_wdata;
      whilo_d = mem_whilo;
      hi_d    = mem_hi;
      lo_d    = mem_lo;
      valid_d = mem_valid;
    end
  end

  // Commit uses the current slot contents, so a flush of the incoming slot
  // does not cancel it; a held slot commits only on its unstalled edge.
  always_comb begin
    hi_arch_d = hi_arch_q;
    lo_arch_d = lo_arch_q;
    cnt_d     = cnt_q;
    if (retire && whilo_q) begin
      hi_arch_d = hi_q;
      lo_arch_d = lo_q;
    end
    if (retire && valid_q) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q      <= '0;
      wreg_q    <= 1'b0;
      wdata_q   <= '0;
      whilo_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      valid_q   <= 1'b0;
      hi_arch_q <= '0;
      lo_arch_q <= '0;
      cnt_q     <= '0;
    end else begin
      wd_q      <= wd_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
      whilo_q   <= whilo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      valid_q   <= valid_d;
      hi_arch_q <= hi_arch_d;
      lo_arch_q <= lo_arch_d;
      cnt_q     <= cnt_d;
    end
  end

  assign wb_wd       = wd_q;
  assign wb_wreg     = wreg_q;
  assign wb_wdata    = wdata_q;
  assign wb_whilo    = whilo_q;
  assign wb_hi       = hi_q;
  assign wb_lo       = lo_q;
  assign hi_o        = hi_arch_q;
  assign lo_o        = lo_arch_q;
  assign hi_fwd      = whilo_q ? hi_q : hi_arch_q;
  assign lo_fwd      = whilo_q ? lo_q : lo_arch_q;
  assign retired_cnt = cnt_q;

endmodule
